dma_egress_packer: RTL and testbench

- Egress counterpart to the ingress data path: collects 256-bit signed-hash results and packs two per 512-bit DMA write beat toward the host.
- Buffers beats in a small FIFO under host backpressure.
- Flushes a lone half-beat after a timeout.
- Wipes all buffered data on a physical security alert.

---
 rtl/total_pkg.sv | 20 ++
 rtl/egress_beat_fifo.sv | 64 ++++++
 rtl/dma_egress_packer.sv | 185 ++++++++++++++++++
 tb/tb_dma_egress_packer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/total_pkg.sv
// Shared definitions for the DMA egress packer: widths, status encodings and
// the packer state enumeration.
package total_pkg;

    localparam int RESULT_W = 256;
    localparam int DMA_W    = 512;
    localparam int SEQ_W    = 16;

    localparam logic [1:0] STATUS_IDLE  = 2'b00;
    localparam logic [1:0] STATUS_BUSY  = 2'b01;
    localparam logic [1:0] STATUS_ERROR = 2'b10;
    localparam logic [1:0] STATUS_WIPED = 2'b11;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_WIPED = 2'd2
    } pack_state_t;

endpackage

// File: rtl/egress_beat_fifo.sv
// First-word-fall-through beat FIFO with synchronous clear; output reads as
// zero while empty so downstream sees clean data when nothing is valid.
module egress_beat_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 513
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        dout,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count_reg == FULL_CNT);
    assign empty = (count_reg == '0);
    assign rd_en = pop & ~empty;
    // A push while full is accepted only when a pop frees the slot this cycle.
    assign wr_en = push & (~full | rd_en);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (wr_en) begin
            mem_reg[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign dout  = empty ? '0 : mem_reg[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/dma_egress_packer.sv
// Packs pairs of 256-bit results into 512-bit DMA beats, flushes a lone half
// after a timeout and wipes all state on a security alert.
// Optional beat sequence tag output enabled by defining EGRESS_SEQ_TAG_EN.
module dma_egress_packer
    import total_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int FLUSH_TIMEOUT = 64,
    parameter int STALL_LIMIT   = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [RESULT_W-1:0] result_in,
    input  logic                result_valid,
    output logic                result_ready,
    output logic [DMA_W-1:0]    dma_data_out,
    output logic                dma_valid,
    input  logic                dma_ready,
    output logic                dma_half,
    input  logic                thermal_alert,
    input  logic                tamper_alert,
`ifdef EGRESS_SEQ_TAG_EN
    output logic [SEQ_W-1:0]    dma_seq,
`endif
    output logic [1:0]          status_code
);

    localparam int TMR_W   = $clog2(FLUSH_TIMEOUT + 1);
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);
    localparam logic [TMR_W-1:0]   TMR_MAX   = FLUSH_TIMEOUT[TMR_W-1:0];
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_LIMIT[STALL_W-1:0];
`ifdef EGRESS_SEQ_TAG_EN
    localparam int FIFO_W = DMA_W + 1 + SEQ_W;
`else
    localparam int FIFO_W = DMA_W + 1;
`endif

    pack_state_t          state_reg, state_next;
    logic [RESULT_W-1:0]  lower_reg, lower_next;
    logic [TMR_W-1:0]     timer_reg, timer_next;
    logic [STALL_W-1:0]   stall_reg;
    logic                 armed_reg;

    logic                 breach;
    logic                 accept;
    logic                 pop;
    logic                 push;
    logic                 push_half;
    logic [DMA_W-1:0]     push_data;
    logic [FIFO_W-1:0]    fifo_din;
    logic [FIFO_W-1:0]    fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    assign breach = thermal_alert | tamper_alert;
    assign accept = result_valid & result_ready;
    // Handshakes coinciding with a breach are discarded.
    assign pop    = dma_valid & dma_ready & ~breach;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_EMPTY;
            lower_reg <= '0;
            timer_reg <= '0;
            armed_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            lower_reg <= lower_next;
            timer_reg <= timer_next;
            armed_reg <= 1'b1;
        end
    end

    always_comb begin
        state_next   = state_reg;
        lower_next   = lower_reg;
        timer_next   = timer_reg;
        push         = 1'b0;
        push_half    = 1'b0;
        push_data    = '0;
        result_ready = armed_reg & (state_reg != ST_WIPED) &
                       ((state_reg == ST_EMPTY) | ~fifo_full);

        case (state_reg)
            ST_EMPTY: begin
                if (accept) begin
                    lower_next = result_in;
                    timer_next = '0;
                    state_next = ST_HALF;
                end
            end
            ST_HALF: begin
                if (accept) begin
                    push       = 1'b1;
                    push_data  = {result_in, lower_reg};
                    lower_next = '0;
                    timer_next = '0;
                    state_next = ST_EMPTY;
                end else if (timer_reg == TMR_MAX) begin
                    // Timer holds at the limit while the FIFO is full.
                    if (!fifo_full) begin
                        push       = 1'b1;
                        push_half  = 1'b1;
                        push_data  = {{RESULT_W{1'b0}}, lower_reg};
                        lower_next = '0;
                        timer_next = '0;
                        state_next = ST_EMPTY;
                    end
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_WIPED;
            end
        endcase

        if (breach) begin
            state_next = ST_WIPED;
            lower_next = '0;
            timer_next = '0;
            push       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || breach || state_reg == ST_WIPED) begin
            stall_reg <= '0;
        end else if (pop) begin
            stall_reg <= '0;
        end else if (dma_valid && !dma_ready && stall_reg != STALL_MAX) begin
            stall_reg <= stall_reg + 1'b1;
        end
    end

`ifdef EGRESS_SEQ_TAG_EN
    logic [SEQ_W-1:0] seq_reg;

    always_ff @(posedge clk) begin
        if (!rst_n || breach) begin
            seq_reg <= '0;
        end else if (push) begin
            seq_reg <= seq_reg + 1'b1;
        end
    end

    assign fifo_din = {seq_reg, push_half, push_data};
    assign dma_seq  = fifo_dout[DMA_W+1 +: SEQ_W];
`else
    assign fifo_din = {push_half, push_data};
`endif

    egress_beat_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (breach),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign dma_valid    = ~fifo_empty;
    assign dma_data_out = fifo_dout[DMA_W-1:0];
    assign dma_half     = fifo_dout[DMA_W];

    always_comb begin
        status_code = STATUS_IDLE;
        if (state_reg == ST_WIPED) begin
            status_code = STATUS_WIPED;
        end else if (stall_reg == STALL_MAX) begin
            status_code = STATUS_ERROR;
        end else if ((fifo_count != '0) || (state_reg == ST_HALF)) begin
            status_code = STATUS_BUSY;
        end
    end

endmodule

// File: tb/tb_dma_egress_packer.sv
// Randomized bench for dma_egress_packer against a queue-based reference of
// the packing, flush, stall and wipe rules; one line per delivered beat.
module tb_dma_egress_packer;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;
    localparam int LIMIT   = 1024;

    logic         clk;
    logic         rst_n;
    logic [255:0] result_in;
    logic         result_valid;
    logic         result_ready;
    logic [511:0] dma_data_out;
    logic         dma_valid;
    logic         dma_ready;
    logic         dma_half;
    logic         thermal_alert;
    logic         tamper_alert;
    logic [1:0]   status_code;
`ifdef EGRESS_SEQ_TAG_EN
    logic [15:0]  dma_seq;
`endif

    dma_egress_packer #(
        .FIFO_DEPTH    (DEPTH),
        .FLUSH_TIMEOUT (TIMEOUT),
        .STALL_LIMIT   (LIMIT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .result_in     (result_in),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .dma_data_out  (dma_data_out),
        .dma_valid     (dma_valid),
        .dma_ready     (dma_ready),
        .dma_half      (dma_half),
        .thermal_alert (thermal_alert),
        .tamper_alert  (tamper_alert),
`ifdef EGRESS_SEQ_TAG_EN
        .dma_seq       (dma_seq),
`endif
        .status_code   (status_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] data;
        logic         half;
        logic [15:0]  seq;
    } beat_t;

    // Reference state: expected beats in delivery order plus packer bookkeeping.
    beat_t        mq[$];
    bit           m_valid;
    bit           m_armed;
    bit           m_wiped;
    bit           m_have;
    logic [255:0] m_lower;
    int           m_idle;
    int           m_stall;
    logic [15:0]  m_seq;
    int           n_beats;

    int n_vec;
    int n_err;

    task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_status();
        if (m_wiped) return 2'b11;
        if (m_stall >= LIMIT) return 2'b10;
        if (mq.size() != 0 || m_have) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_armed = 1'b0;
        m_wiped = 1'b0;
        m_have  = 1'b0;
        m_lower = '0;
        m_idle  = 0;
        m_stall = 0;
        m_seq   = '0;
        m_valid = 1'b1;
    endtask

    // One clock: compare outputs mid-cycle, then advance the model across the edge.
    task automatic step();
        bit    m_ready;
        bit    accept;
        bit    pop;
        bit    do_push;
        beat_t b;
        @(negedge clk);
        m_ready = m_armed && !m_wiped && (!m_have || mq.size() < DEPTH);
        if (m_valid) begin
            check_val("result_ready", 512'(result_ready), 512'(m_ready));
            check_val("dma_valid", 512'(dma_valid), 512'(mq.size() != 0));
            check_val("dma_data", dma_data_out, (mq.size() != 0) ? mq[0].data : 512'h0);
            check_val("dma_half", 512'(dma_half), 512'((mq.size() != 0) ? mq[0].half : 1'b0));
            check_val("status", 512'(status_code), 512'(exp_status()));
`ifdef EGRESS_SEQ_TAG_EN
            check_val("dma_seq", 512'(dma_seq), 512'((mq.size() != 0) ? mq[0].seq : 16'h0));
`endif
        end
        if (!rst_n) begin
            model_reset();
        end else if (thermal_alert || tamper_alert) begin
            mq.delete();
            m_wiped = 1'b1;
            m_have  = 1'b0;
            m_lower = '0;
            m_idle  = 0;
            m_stall = 0;
            m_seq   = '0;
        end else begin
            accept  = result_valid && m_ready;
            pop     = (mq.size() != 0) && dma_ready;
            do_push = 1'b0;
            b.data  = '0;
            b.half  = 1'b0;
            b.seq   = '0;
            if (m_have) begin
                if (accept) begin
                    b.data  = {result_in, m_lower};
                    do_push = 1'b1;
                    m_have  = 1'b0;
                    m_idle  = 0;
                end else if (m_idle == TIMEOUT) begin
                    if (mq.size() < DEPTH) begin
                        b.data  = {256'h0, m_lower};
                        b.half  = 1'b1;
                        do_push = 1'b1;
                        m_have  = 1'b0;
                        m_idle  = 0;
                    end
                end else begin
                    m_idle++;
                end
            end else if (accept) begin
                m_have  = 1'b1;
                m_lower = result_in;
                m_idle  = 0;
            end
            if (pop) m_stall = 0;
            else if (mq.size() != 0 && m_stall < LIMIT) m_stall++;
            if (pop) begin
                n_beats++;
                $display("beat %0d seq=%0h half=%0b data=%0h", n_beats, mq[0].seq, mq[0].half, mq[0].data);
                void'(mq.pop_front());
            end
            if (do_push) begin
                b.seq = m_seq;
                m_seq = m_seq + 16'd1;
                mq.push_back(b);
            end
            m_armed = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic apply_reset();
        rst_n         = 1'b0;
        result_valid  = 1'b0;
        thermal_alert = 1'b0;
        tamper_alert  = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [255:0] d);
        result_in    = d;
        result_valid = 1'b1;
        step();
        result_valid = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        n_beats = 0;
        m_valid = 1'b0;
        rst_n = 1'b0;
        result_in = '0;
        result_valid = 1'b0;
        dma_ready = 1'b1;
        thermal_alert = 1'b0;
        tamper_alert = 1'b0;

        apply_reset();
        run_idle(3);

        // A then B back to back, host ready.
        result_in = rand256();
        result_valid = 1'b1;
        step();
        result_in = rand256();
        step();
        result_valid = 1'b0;
        run_idle(4);

        // Lone result flushed as a half beat after the timeout.
        send(rand256());
        run_idle(TIMEOUT + 6);

        // Second result arriving exactly on the timeout cycle wins.
        send(rand256());
        for (int k = 0; k < 2 * TIMEOUT && m_idle < TIMEOUT; k++) step();
        send(rand256());
        run_idle(4);

        // Backpressure: stream results into a stalled host, then drain.
        dma_ready = 1'b0;
        for (int k = 0; k < 14; k++) begin
            result_in = rand256();
            result_valid = 1'b1;
            step();
        end
        result_valid = 1'b0;
        dma_ready = 1'b1;
        run_idle(TIMEOUT + 12);

        // Long stall reaches ERROR; a pop recovers.
        dma_ready = 1'b0;
        send(rand256());
        send(rand256());
        run_idle(LIMIT + 6);
        dma_ready = 1'b1;
        run_idle(4);

        // Random traffic without alerts.
        for (int k = 0; k < 2000; k++) begin
            result_in = rand256();
            result_valid = ($urandom_range(0, 2) != 0);
            dma_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        result_valid = 1'b0;
        dma_ready = 1'b1;
        run_idle(TIMEOUT + 8);

        // Tamper with three beats buffered; wipe is sticky until reset.
        dma_ready = 1'b0;
        for (int k = 0; k < 6; k++) send(rand256());
        tamper_alert = 1'b1;
        result_in = rand256();
        result_valid = 1'b1;
        dma_ready = 1'b1;
        step();
        tamper_alert = 1'b0;
        for (int k = 0; k < 12; k++) begin
            result_in = rand256();
            result_valid = $urandom_range(0, 1);
            dma_ready = $urandom_range(0, 1);
            step();
        end
        apply_reset();
        dma_ready = 1'b1;
        send(rand256());
        send(rand256());
        run_idle(4);

        // Random traffic with occasional alerts and resets.
        for (int k = 0; k < 3000; k++) begin
            result_in = rand256();
            result_valid = ($urandom_range(0, 2) != 0);
            dma_ready = ($urandom_range(0, 2) != 0);
            thermal_alert = ($urandom_range(0, 599) == 0);
            tamper_alert = ($urandom_range(0, 599) == 0);
            rst_n = ($urandom_range(0, 399) != 0) && !(m_wiped && $urandom_range(0, 19) == 0);
            step();
        end
        rst_n = 1'b1;
        thermal_alert = 1'b0;
        tamper_alert = 1'b0;
        result_valid = 1'b0;
        run_idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
